// File: rtl/regs_pkg.sv
// regs_pkg: shared register-file geometry and dump-sequencer state encoding.
package regs_pkg;
  localparam int REGS_ADDR_W = 4;
  localparam int REGS_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, CSUM} state_t;
endpackage

// File: rtl/regs_dump.sv
// regs_dump: walks a wrapping register range and streams each word out on valid/ready.
// Define REGS_DUMP_CSUM_EN to append an XOR checksum beat after the register words.
module regs_dump
  import regs_pkg::*;
#(
  parameter int ADDR_W = REGS_ADDR_W,
  parameter int DATA_W = REGS_DATA_W
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [ADDR_W:0] rem, rem_n;
  logic [DATA_W-1:0] data_n;
  logic valid_n, last_n, done_n;
`ifdef REGS_DUMP_CSUM_EN
  logic [DATA_W-1:0] csum, csum_n;
`endif
  assign r_addr = addr;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    addr_n = addr;
    rem_n = rem;
    data_n = m_data;
    valid_n = m_valid;
    last_n = m_last;
    done_n = 1'b0;
`ifdef REGS_DUMP_CSUM_EN
    csum_n = csum;
`endif
    case (state)
      IDLE: if (start) begin
        addr_n = start_addr;
        rem_n = len;
`ifdef REGS_DUMP_CSUM_EN
        csum_n = '0;
        state_n = LOAD;
`else
        state_n = (len == '0) ? IDLE : LOAD;
        done_n = len == '0;
`endif
      end
`ifdef REGS_DUMP_CSUM_EN
      // An empty or exhausted range goes straight to the checksum beat.
      LOAD: begin
        valid_n = 1'b1;
        if (rem == '0) begin
          data_n = csum;
          last_n = 1'b1;
          state_n = CSUM;
        end else begin
          data_n = r_data;
          csum_n = csum ^ r_data;
          addr_n = addr + 1'b1;
          rem_n = rem - 1'b1;
          state_n = STREAM;
        end
      end
      STREAM: if (m_ready) begin
        if (rem == '0) begin
          data_n = csum;
          last_n = 1'b1;
          state_n = CSUM;
        end else begin
          data_n = r_data;
          csum_n = csum ^ r_data;
          addr_n = addr + 1'b1;
          rem_n = rem - 1'b1;
        end
      end
      CSUM: if (m_ready) begin
        valid_n = 1'b0;
        last_n = 1'b0;
        done_n = 1'b1;
        state_n = IDLE;
      end
`else
      LOAD: begin
        data_n = r_data;
        valid_n = 1'b1;
        last_n = rem == (ADDR_W+1)'(1);
        addr_n = addr + 1'b1;
        rem_n = rem - 1'b1;
        state_n = STREAM;
      end
      STREAM: if (m_ready) begin
        if (m_last) begin
          valid_n = 1'b0;
          last_n = 1'b0;
          done_n = 1'b1;
          state_n = IDLE;
        end else begin
          data_n = r_data;
          last_n = rem == (ADDR_W+1)'(1);
          addr_n = addr + 1'b1;
          rem_n = rem - 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      m_data <= '0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      done <= 1'b0;
`ifdef REGS_DUMP_CSUM_EN
      csum <= '0;
`endif
    end else begin
      state <= state_n;
      addr <= addr_n;
      rem <= rem_n;
      m_data <= data_n;
      m_valid <= valid_n;
      m_last <= last_n;
      done <= done_n;
`ifdef REGS_DUMP_CSUM_EN
      csum <= csum_n;
`endif
    end
  end
endmodule

// File: tb/tb_regs_dump.sv
// tb_regs_dump: randomized self-checking bench for regs_dump against a list-based dump model.
// Honours REGS_DUMP_CSUM_EN the same way the design does.
module tb_regs_dump;
  logic clk_in = 1'b0;
  logic rst, start, m_ready;
  logic [3:0] start_addr, r_addr;
  logic [4:0] len;
  logic [7:0] r_data, m_data;
  logic m_valid, m_last, busy, done;
  logic [7:0] regs [16];
  int tests, fails;
  logic [7:0] got_d[$];
  logic got_l[$];
  logic [7:0] exp_d[$];
  int first_v, last_hs, done_cyc, stab_err;
  bit timed_out;

  regs_dump dut (
    .clk_in(clk_in), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .r_addr(r_addr), .r_data(r_data), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
  );

  assign r_data = regs[r_addr];
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Expected beat list: the words of the wrapped range, plus their XOR when checksumming.
  task automatic build_expected(input int sa, input int ln);
    logic [7:0] x;
    x = 8'h00;
    exp_d.delete();
    for (int i = 0; i < ln; i++) begin
      exp_d.push_back(regs[(sa + i) % 16]);
      x = x ^ regs[(sa + i) % 16];
    end
`ifdef REGS_DUMP_CSUM_EN
    exp_d.push_back(x);
`endif
  endtask

  task automatic dump(input logic [3:0] sa, input logic [4:0] ln, input int rmode, input bit poke);
    logic [7:0] pd;
    bit pstall;
    got_d.delete();
    got_l.delete();
    first_v = -1; last_hs = -1; done_cyc = -1; stab_err = 0; timed_out = 0; pstall = 0; pd = 8'h00;
    start = 1'b1; start_addr = sa; len = ln;
    step();
    start = 1'b0; start_addr = 4'($urandom); len = 5'($urandom);
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (poke) start = (cyc == 3);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (pstall && (!m_valid || m_data !== pd)) stab_err++;
      if (m_valid && first_v < 0) first_v = cyc;
      m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 3) == 2) : 1'($urandom_range(0, 1));
      pstall = m_valid && !m_ready;
      pd = m_data;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        last_hs = cyc;
      end
      step();
    end
    start = 1'b0;
    if (done_cyc < 0) timed_out = 1;
  endtask

  task automatic test_dump(input string name, input logic [3:0] sa, input logic [4:0] ln, input int rmode, input bit poke);
    int n;
    build_expected(sa, ln);
    dump(sa, ln, rmode, poke);
    tests++;
    if (timed_out) begin
      fails++;
      $display("FAIL %s timeout: no done within budget", name);
    end
    tests++;
    if (got_d.size() !== exp_d.size()) begin
      fails++;
      $display("FAIL %s beat count: got %0d want %0d", name, got_d.size(), exp_d.size());
    end
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      tests++;
      if (got_d[i] !== exp_d[i]) begin
        fails++;
        $display("FAIL %s data[%0d]: got %h want %h", name, i, got_d[i], exp_d[i]);
      end
      tests++;
      if (got_l[i] !== 1'(i == exp_d.size() - 1)) begin
        fails++;
        $display("FAIL %s last[%0d]: got %b want %b", name, i, got_l[i], i == exp_d.size() - 1);
      end
    end
    if (exp_d.size() > 0) begin
      tests++;
      if (first_v !== 2) begin
        fails++;
        $display("FAIL %s start-to-valid: got %0d want 2", name, first_v);
      end
      tests++;
      if (done_cyc !== last_hs + 1) begin
        fails++;
        $display("FAIL %s done timing: got cycle %0d want %0d", name, done_cyc, last_hs + 1);
      end
    end else begin
      tests++;
      if (done_cyc !== 1) begin
        fails++;
        $display("FAIL %s empty done timing: got cycle %0d want 1", name, done_cyc);
      end
    end
    tests++;
    if (stab_err !== 0) begin
      fails++;
      $display("FAIL %s stall stability: got %0d violations want 0", name, stab_err);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s busy at done: got %b want 0", name, busy);
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) regs[i] = 8'(8'h10 + i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    tests++;
    if ({r_addr, m_data, m_valid, m_last, busy, done} !== 16'h0) begin
      fails++;
      $display("FAIL reset outputs: got r_addr=%h m_data=%h v=%b l=%b busy=%b done=%b want all 0",
               r_addr, m_data, m_valid, m_last, busy, done);
    end
    rst = 1'b0;
    step();
    tests++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset idle: got busy=%b valid=%b want 0 0", busy, m_valid);
    end
  endtask

  task automatic test_basic();
    fill_ramp();
    test_dump("basic", 4'd3, 5'd4, 0, 0);
    tests++;
    if (got_d.size() < 4 || got_d[0] !== 8'h13 || got_d[3] !== 8'h16) begin
      fails++;
      $display("FAIL basic words: got first=%h fourth=%h want 13 16",
               got_d.size() > 0 ? got_d[0] : 8'hxx, got_d.size() > 3 ? got_d[3] : 8'hxx);
    end
    step();
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic after done: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_wrap();
    fill_ramp();
    test_dump("wrap", 4'd14, 5'd4, 0, 0);
    tests++;
    if (got_d.size() < 4 || got_d[1] !== 8'h1F || got_d[2] !== 8'h10) begin
      fails++;
      $display("FAIL wrap words: got second=%h third=%h want 1f 10",
               got_d.size() > 1 ? got_d[1] : 8'hxx, got_d.size() > 2 ? got_d[2] : 8'hxx);
    end
    step();
  endtask

  task automatic test_full_backpressure();
    fill_random();
    test_dump("full16", 4'd9, 5'd16, 1, 0);
    step();
  endtask

  task automatic test_len0();
    fill_random();
    test_dump("len0", 4'd5, 5'd0, 0, 0);
    step();
  endtask

  task automatic test_start_while_busy();
    fill_random();
    test_dump("busy_start", 4'd2, 5'd8, 2, 1);
    repeat (4) begin
      step();
      tests++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL busy_start queued: got valid=%b busy=%b want 0 0", m_valid, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    test_dump("b2b_a", 4'd11, 5'd5, 0, 0);
    test_dump("b2b_b", 4'd0, 5'd3, 2, 0);
    step();
  endtask

  task automatic test_reset_mid();
    int hs, bad;
    fill_random();
    hs = 0;
    start = 1'b1; start_addr = 4'd5; len = 5'd10;
    step();
    start = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 20 && hs < 2; c++) begin
      if (m_valid) hs++;
      if (hs < 2) step();
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid abort: got valid=%b busy=%b done=%b want 0 0 0", m_valid, busy, done);
    end
    bad = 0;
    repeat (6) begin
      step();
      if (m_valid || done) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL reset_mid quiet: got %0d active cycles want 0", bad);
    end
    test_dump("after_reset", 4'd7, 5'd6, 0, 0);
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      fill_random();
      test_dump("random", 4'($urandom), 5'($urandom_range(0, 16)), 2, 0);
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

`ifdef REGS_DUMP_CSUM_EN
  task automatic test_csum();
    fill_random();
    regs[0] = 8'h01; regs[1] = 8'h02; regs[2] = 8'h04;
    test_dump("csum", 4'd0, 5'd3, 0, 0);
    tests++;
    if (got_d.size() !== 4 || got_d[3] !== 8'h07 || got_l[2] !== 1'b0) begin
      fails++;
      $display("FAIL csum beat: got size=%0d fourth=%h want 4 beats ending 07 with no last on 04",
               got_d.size(), got_d.size() > 3 ? got_d[3] : 8'hxx);
    end
    step();
  endtask
`endif

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; start = 1'b0; start_addr = 4'd0; len = 5'd0; m_ready = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    test_reset();
    test_basic();
    test_wrap();
    test_full_backpressure();
    test_len0();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef REGS_DUMP_CSUM_EN
    test_csum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
